layer_output_collector: RTL
===========================

Name: layer_output_collector

Overview:
- Sits directly upstream of the argmax stage, after the final neuron layer.
- Gathers per-neuron results that finish in arbitrary cycles and optional ReLU-clamps them so the downstream unsigned compare is correct.
- Packs them into one flat vector and emits a single-cycle valid pulse per complete frame.
- Flags duplicate reports and stalled frames (timeout).

Parameters:
- data_width, 16, bit-width of each neuron result (two's complement).
- no_neurons, 10, number of neurons per frame (lanes).
- relu_enable, 1, 1 = negative results stored as zero; 0 = stored unchanged.
- timeout_cycles, 1024, maximum cycles a frame may stay open after its first arrival; must be >= 2.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- neuron_valid  input  no_neurons  bit i = lane i result valid this cycle.
- neuron_data  input  data_width*no_neurons  lane i at bits [i*data_width +: data_width].
- valid_output  output  1  one-cycle pulse: data_out holds a complete frame.
- data_out  output  data_width*no_neurons  packed frame, lane 0 in LSBs; held until next emit.
- busy  output  1  high while a frame is partially collected (state COLLECT).
- dup_error  output  1  sticky: a lane reported twice within one frame.
- timeout_error  output  1  sticky: a frame was dropped on timeout.

Behaviour:
- Reset: applies when rst is high at a clock edge.
  - All outputs go to 0.
  - Receive mask, internal buffer and timer are cleared; state = IDLE.
  - Reset mid-frame drops the partial frame silently, with no emit and no error.
- Lane transform: if relu_enable and lane MSB = 1, the stored value is 0; otherwise the raw value is stored. No other width change.
- State IDLE (mask = 0, timer = 0):
  - Any neuron_valid bit set: capture those lanes, set their mask bits, timer = 1, go to COLLECT.
  - If all no_neurons bits are set in that same cycle, emit immediately (see Emit) and stay in IDLE.
- State COLLECT:
  - Each cycle, capture lanes whose valid = 1 and mask = 0, and set those mask bits.
  - valid = 1 on a lane whose mask = 1: the first value is kept, the new value is ignored, dup_error <= 1.
  - Mask becomes all ones (including lanes captured this cycle): emit, clear mask and timer, go to IDLE.
  - Otherwise timer increments. If timer == timeout_cycles-1 and the frame did not complete this cycle: timeout_error <= 1, clear mask/buffer/timer, go to IDLE, no emit.
- Emit:
  - At the completing edge, data_out <= buffer merged with this cycle's captured lanes, and valid_output <= 1.
  - On the following edge valid_output <= 0 unless another frame completes.
  - Latency: valid_output is high in the cycle immediately after the cycle whose sampled valid completed the frame.
- Back-to-back frames: neuron_valid in the cycle valid_output is high starts a new frame in IDLE. data_out is not disturbed until that frame's own emit.
- Simultaneous events:
  - Completion and timeout on the same edge: completion wins, no timeout_error.
  - Duplicate and completion on the same edge: dup_error set and frame emitted with first-arrival values.
- busy = 1 exactly while in COLLECT.
- dup_error and timeout_error clear only on rst.
- Timer width is $clog2(timeout_cycles)+1. The timer never wraps.

Test Plan:
- Defaults, all 10 lanes valid in one cycle with lane i = i*100: the next cycle has valid_output = 1 for exactly one cycle, data_out lane 7 = 700, busy never high.
- Lanes 0-4 valid at cycle 0, lanes 5-9 valid at cycle 3, lane 9 = 16'hFFF0:
  - busy high in cycles 1-3.
  - valid_output pulses in cycle 4.
  - With relu_enable = 1, lane 9 of data_out = 0; with relu_enable = 0, it = 16'hFFF0.
- Lane 2 valid with 5, then lane 2 again with 9 before completion, remaining lanes follow: dup_error = 1, emitted lane 2 = 5, exactly one valid_output pulse.
- timeout_cycles = 8, only lanes 0-8 ever valid from cycle 0:
  - timeout_error = 1 after cycle 7, busy = 0, no valid_output.
  - A later full frame then emits normally.
- Frame A completes; all lanes for frame B are asserted in frame A's valid_output cycle: data_out holds A during its pulse, then B pulses the next cycle with B's values.
- rst asserted after 5 of 10 lanes captured, then lanes 5-9 only: no valid_output, busy high after the new arrivals, errors remain 0.

Source files
------------

// File: rtl/layer_output_collector.sv
// Collects per-lane neuron results arriving in any order, optionally ReLU-clamps them,
// and emits one packed frame with a single-cycle valid pulse once every lane has reported.

module layer_output_collector_lane #(
    parameter int data_width  = 16,
    parameter int relu_enable = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  cap,
    input  logic [data_width-1:0] din,
    output logic [data_width-1:0] merged
);
    logic [data_width-1:0] xf;
    logic [data_width-1:0] buf_q;

    // Clamping negatives keeps the unsigned argmax compare downstream correct.
    assign xf     = (relu_enable != 0 && din[data_width-1]) ? '0 : din;
    assign merged = cap ? xf : buf_q;

    always_ff @(posedge clk) begin
        if (rst || clr) buf_q <= '0;
        else if (cap)   buf_q <= xf;
    end
endmodule

module layer_output_collector #(
    parameter int data_width     = 16,
    parameter int no_neurons     = 10,
    parameter int relu_enable    = 1,
    parameter int timeout_cycles = 1024
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [no_neurons-1:0]            neuron_valid,
    input  logic [data_width*no_neurons-1:0] neuron_data,
    output logic                             valid_output,
    output logic [data_width*no_neurons-1:0] data_out,
    output logic                             busy,
    output logic                             dup_error,
    output logic                             timeout_error
);
    localparam int TW = $clog2(timeout_cycles) + 1;
    localparam logic [TW-1:0] T_LAST = TW'(timeout_cycles - 1);

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t                                  state_q, state_d;
    logic [no_neurons-1:0]                   mask_q, mask_d;
    logic [TW-1:0]                           timer_q, timer_d;
    logic [no_neurons-1:0]                   cap;
    logic [no_neurons-1:0][data_width-1:0]   merged;
    logic [no_neurons-1:0][data_width-1:0]   data_q;
    logic                                    full, dup, emit, clr, tout;

    assign cap  = neuron_valid & ~mask_q;
    assign full = &(mask_q | neuron_valid);
    assign dup  = |(neuron_valid & mask_q);
    assign busy = (state_q == COLLECT);
    assign data_out = data_q;

    genvar i;
    generate
        for (i = 0; i < no_neurons; i++) begin : g_lane
            layer_output_collector_lane #(
                .data_width (data_width),
                .relu_enable(relu_enable)
            ) u_lane (
                .clk   (clk),
                .rst   (rst),
                .clr   (clr),
                .cap   (cap[i]),
                .din   (neuron_data[i*data_width +: data_width]),
                .merged(merged[i])
            );
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        timer_d = timer_q;
        emit    = 1'b0;
        clr     = 1'b0;
        tout    = 1'b0;
        case (state_q)
            IDLE: begin
                if (|neuron_valid) begin
                    if (full) begin
                        emit = 1'b1;
                        clr  = 1'b1;
                    end else begin
                        mask_d  = neuron_valid;
                        timer_d = TW'(1);
                        state_d = COLLECT;
                    end
                end
            end
            COLLECT: begin
                mask_d = mask_q | neuron_valid;
                // Completion is checked first so it wins over a same-edge timeout.
                if (full) begin
                    emit    = 1'b1;
                    clr     = 1'b1;
                    mask_d  = '0;
                    timer_d = '0;
                    state_d = IDLE;
                end else if (timer_q == T_LAST) begin
                    tout    = 1'b1;
                    clr     = 1'b1;
                    mask_d  = '0;
                    timer_d = '0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                mask_d  = '0;
                timer_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            mask_q        <= '0;
            timer_q       <= '0;
            valid_output  <= 1'b0;
            data_q        <= '0;
            dup_error     <= 1'b0;
            timeout_error <= 1'b0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            timer_q      <= timer_d;
            valid_output <= emit;
            if (emit) data_q <= merged;
            if (dup)  dup_error <= 1'b1;
            if (tout) timeout_error <= 1'b1;
        end
    end
endmodule
